// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// R-type function codes and ALU select codes. The ALU and the datapath
// use the same package.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_BNE = 3'b111;

    // True for the R-type function codes the datapath implements.
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: funct_legal = 1'b1;
            default:                                        funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the controller state plus op/funct to the ALU select
// code and the immediate zero-extend flag. Purely combinational.
module mc_alu_dec
    import mc_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_sel,
    output logic       ext_zero
);

    // Select the ALU operation; only REX, BRANCH and IEX use anything but add.
    always_comb begin
        alu_sel  = ALU_ADD;
        ext_zero = 1'b0;
        case (state)
            S_REX: begin
                case (funct)
                    F_SUB:   alu_sel = ALU_SUB;
                    F_AND:   alu_sel = ALU_AND;
                    F_OR:    alu_sel = ALU_OR;
                    F_XOR:   alu_sel = ALU_XOR;
                    F_NOR:   alu_sel = ALU_NOR;
                    F_SLT:   alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            S_BRANCH: alu_sel = (op == OP_BNE) ? ALU_BNE : ALU_SUB;
            S_IEX: begin
                case (op)
                    OP_ANDI: begin alu_sel = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin alu_sel = ALU_OR;  ext_zero = 1'b1; end
                    OP_XORI: begin alu_sel = ALU_XOR; ext_zero = 1'b1; end
                    OP_SLTI: alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style controller: Moore FSM sequencing fetch, decode,
// execute and writeback. Strobes are forced low while reset is asserted so
// an interrupted instruction never writes memory or the register file.
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       ext_zero,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_sel,
    output logic       pc_en,
    output logic       retire,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_write_s, ir_write_s;
    logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s, retire_s;
    logic       ext_zero_s;

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d         = S_FETCH;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        retire_s        = 1'b0;
        alu_src_b       = 2'b00;
        pc_src          = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = 2'b01;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_IEX;
                    OP_J:           state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) state_d = S_REX;
                        else                    retire_s = 1'b1;
                    end
                    default:        retire_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b   = 2'b10;
                state_d     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                i_or_d_s = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                retire_s     = 1'b1;
            end
            S_MEMWR: begin
                i_or_d_s    = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_REX: begin
                alu_src_a_s = 1'b1;
                state_d     = S_RWB;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                retire_s    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                pc_write_cond_s = 1'b1;
                pc_src          = 2'b01;
                retire_s        = 1'b1;
            end
            S_IEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b   = 2'b10;
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_src     = 2'b10;
                retire_s   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .state    (state_q),
        .op       (op),
        .funct    (funct),
        .alu_sel  (alu_sel),
        .ext_zero (ext_zero_s)
    );

    assign pc_write      = pc_write_s      & rst_n;
    assign pc_write_cond = pc_write_cond_s & rst_n;
    assign i_or_d        = i_or_d_s        & rst_n;
    assign mem_write     = mem_write_s     & rst_n;
    assign ir_write      = ir_write_s      & rst_n;
    assign reg_dst       = reg_dst_s       & rst_n;
    assign mem_to_reg    = mem_to_reg_s    & rst_n;
    assign reg_write     = reg_write_s     & rst_n;
    assign alu_src_a     = alu_src_a_s     & rst_n;
    assign ext_zero      = ext_zero_s      & rst_n;
    assign retire        = retire_s        & rst_n;
    assign pc_en         = pc_write | (pc_write_cond & zero);
    assign state         = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: directed scenarios plus random instruction
// streams checked cycle by cycle against an instruction-level model.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_write, pc_write_cond, i_or_d, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_sel;
    logic       pc_en, retire;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .ext_zero(ext_zero), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_sel(alu_sel), .pc_en(pc_en), .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (instruction level) ----------------
    // Instruction classes: 0 nop/illegal, 1 lw, 2 sw, 3 R-type, 4 I-type, 5 branch, 6 jump
    function automatic int m_kind(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b100110 || f == 6'b100111 ||
                               f == 6'b101010) ? 3 : 0;
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: return 4;
            6'b000100, 6'b000101: return 5;
            6'b000010: return 6;
            default:   return 0;
        endcase
    endfunction

    // ALU operation used in the instruction's execute step.
    function automatic logic [2:0] m_alu(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) begin
            case (f)
                6'b100010: return 3'b001;
                6'b100100: return 3'b010;
                6'b100101: return 3'b011;
                6'b100110: return 3'b100;
                6'b100111: return 3'b101;
                6'b101010: return 3'b110;
                default:   return 3'b000;
            endcase
        end
        case (o)
            6'b001100: return 3'b010;
            6'b001101: return 3'b011;
            6'b001110: return 3'b100;
            6'b001010: return 3'b110;
            6'b000100: return 3'b001;
            6'b000101: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected sequence of visited states for one instruction.
    function automatic void m_trace(input int kind, output int q[$]);
        case (kind)
            1: q = '{0, 1, 2, 3, 4};
            2: q = '{0, 1, 2, 5};
            3: q = '{0, 1, 6, 7};
            4: q = '{0, 1, 9, 10};
            5: q = '{0, 1, 8};
            6: q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
    endfunction

    // Runs one instruction starting in FETCH; checks every cycle at negedge+1.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int q[$];
        int s, last, retires;
        logic ez;
        logic [15:0] obs, exp;
        m_trace(m_kind(o, f), q);
        last    = q.size() - 1;
        retires = 0;
        ez = (o == 6'b001100 || o == 6'b001101 || o == 6'b001110);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk); #1;
            s = q[i];
            n_cmp++;
            if (state !== 4'(s)) begin
                n_bad++;
                $display("FAIL state op=%b funct=%b cyc=%0d got=%0d want=%0d", o, f, i, state, s);
            end
            obs = {reg_write, mem_write, retire, pc_en, i_or_d, ext_zero, ir_write,
                   alu_sel, alu_src_b, pc_src, pc_write_cond};
            exp = {1'(s == 4 || s == 7 || s == 10), 1'(s == 5), 1'(i == last),
                   1'(s == 0 || s == 11 || (s == 8 && z)), 1'(s == 3 || s == 5),
                   1'(s == 9 && ez), 1'(s == 0),
                   (s == 6 || s == 8 || s == 9) ? m_alu(o, f) : 3'b000,
                   (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00,
                   (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00,
                   1'(s == 8)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL outputs op=%b funct=%b st=%0d got=%b want=%b", o, f, s, obs, exp);
            end
            if (s == 4 || s == 7 || s == 10) begin
                n_cmp++;
                if ({reg_dst, mem_to_reg} !== {1'(s == 7), 1'(s == 4)}) begin
                    n_bad++;
                    $display("FAIL wb_sel st=%0d got=%b%b want=%b%b", s, reg_dst, mem_to_reg,
                             1'(s == 7), 1'(s == 4));
                end
            end
            if (retire === 1'b1) retires++;
            if (i == 0) begin
                op = o; funct = f; zero = z;
            end
        end
        n_cmp++;
        if (retires != 1) begin
            n_bad++;
            $display("FAIL retire_count op=%b got=%0d want=1", o, retires);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1; op = 6'b100011; funct = 0; zero = 0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state !== 4'd0) begin
            n_bad++; $display("FAIL reset_async_state got=%0d want=0", state);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({state, pc_write, ir_write, reg_write, mem_write, retire, pc_en} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_hold got=%b want=0", {state, pc_write, ir_write, reg_write,
                     mem_write, retire, pc_en});
        end
        // Release just after an edge: the next rising edge executes FETCH.
        rst_n = 1'b1;
    endtask

    task automatic test_lw();          run_instr(6'b100011, 6'd0, 1'b0); endtask
    task automatic test_rtype_nor();   run_instr(6'b000000, 6'b100111, 1'b0); endtask
    task automatic test_bne();
        run_instr(6'b000101, 6'd0, 1'b1);
        run_instr(6'b000101, 6'd0, 1'b0);
        run_instr(6'b000100, 6'd0, 1'b1);
    endtask
    task automatic test_itype();
        run_instr(6'b001101, 6'd0, 1'b0);
        run_instr(6'b001010, 6'd0, 1'b0);
    endtask
    task automatic test_illegal();
        run_instr(6'b111111, 6'd0, 1'b0);
        run_instr(6'b000000, 6'b000001, 1'b0);
    endtask

    task automatic test_back_to_back_random();
        logic [5:0] ops[12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                6'b000010, 6'b111111};
        logic [5:0] fns[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010};
        logic [5:0] o, f;
        for (int k = 0; k < 80; k++) begin
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr(o, f, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_memwr();
        int guard;
        @(negedge clk); #1;
        op = 6'b101011; funct = 0;
        guard = 0;
        while (state !== 4'd5 && guard < 8) begin
            @(negedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (state !== 4'd5) begin
            n_bad++; $display("FAIL reach_memwr got=%0d want=5", state);
        end
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++; $display("FAIL memwr_strobe got=%b want=1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, mem_write, reg_write, retire} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid_memwr got=%b want=0", {state, mem_write, reg_write, retire});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(6'b101011, 6'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_nor();
        test_bne();
        test_itype();
        test_illegal();
        test_back_to_back_random();
        test_reset_mid_memwr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: op  in  6  instruction[31:26] from the instruction register; funct  in  6  instruction[5:0].
REQ-004 SHALL have ports: zero  in  1  ALU zero flag. For sel 111 the flag is already inverted, so the flag means "branch taken" for both beq and bne.
REQ-005 SHALL have ports: pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero  out  1 each; the single-bit control strobes.
REQ-006 SHALL have ports: alu_src_b  out  2  (00 B reg, 01 const 4, 10 ext imm, 11 ext imm<<2); pc_src  out  2  (00 ALU y, 01 ALUOut reg, 10 jump target).
REQ-007 SHALL have ports: alu_sel  out  3  (ALU op code); pc_en  out  1  (pc_write | (pc_write_cond & zero)); retire  out  1  (one-cycle pulse per completed instruction); state  out  4  (debug).

Function
REQ-008 SHALL be a Moore FSM. All outputs except pc_en are decoded from the state register, plus op/funct, which are stable while ir_write=0.
REQ-009 SHALL use these state encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, IEX 9, IWB 10, JUMP 11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-010 In FETCH, SHALL assert ir_write=1 and pc_write=1, with alu_src_a=0, alu_src_b=01, alu_sel=000, and pc_src=00. Next state: DECODE.
REQ-011 In DECODE, SHALL drive alu_src_a=0, alu_src_b=11, alu_sel=000 (branch target into ALUOut). Next state SHALL be chosen by op:
  - 100011 or 101011 -> MEMADR
  - 000000 with a legal funct -> REX
  - 000100 or 000101 -> BRANCH
  - 001000, 001100, 001101, 001110 or 001010 -> IEX
  - 000010 -> JUMP
  - anything else, including an illegal funct -> FETCH, with retire=1 (treated as a nop).
REQ-012 In MEMADR, SHALL drive alu_src_a=1, alu_src_b=10, alu_sel=000. Next state: MEMRD for lw, MEMWR for sw.
REQ-013 In MEMRD, SHALL drive i_or_d=1, then go to MEMWB. In MEMWB, SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, retire=1, then go to FETCH.
REQ-014 In MEMWR, SHALL drive i_or_d=1, mem_write=1, retire=1, then go to FETCH.
REQ-015 In REX, SHALL drive alu_src_a=1 and alu_src_b=00, with alu_sel from funct: 100000->000, 100010->001, 100100->010, 100101->011, 100110->100, 100111->101, 101010->110. Next state: RWB.
REQ-016 In RWB, SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, retire=1, then go to FETCH.
REQ-017 In BRANCH, SHALL drive alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_src=01, retire=1, with alu_sel=001 for beq and 111 for bne. Next state: FETCH.
REQ-018 In IEX, SHALL drive alu_src_a=1 and alu_src_b=10.
  - alu_sel: addi 000, andi 010, ori 011, xori 100, slti 110.
  - ext_zero=1 for andi/ori/xori, otherwise 0.
  - Next state: IWB.
REQ-019 In IWB, SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, retire=1, then go to FETCH.
REQ-020 In JUMP, SHALL drive pc_write=1, pc_src=10, retire=1, then go to FETCH.
REQ-021 Every strobe not listed for a state SHALL be 0; alu_sel, alu_src_b and pc_src not listed SHALL be 000/00/00.
REQ-022 Instruction latencies SHALL be, in cycles: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3, illegal 2.

Reset
REQ-023 rst_n=0 SHALL immediately force state=FETCH, independent of clk.
REQ-024 While rst_n=0, all strobes and retire SHALL be 0. Asserting reset mid-instruction SHALL abandon the instruction with no mem_write or reg_write.
REQ-025 The first rising edge after rst_n rises SHALL execute FETCH.

Structure
REQ-026 Opcodes, functs, state codes and ALU sel codes (000 add … 111 bne-sub) SHALL live in a shared package or include, reused by the ALU and the datapath.
REQ-027 The block SHALL contain one sub-module, mc_alu_dec, a combinational mapping of op/funct/state to alu_sel and ext_zero.

Verification
REQ-028 Release rst_n and hold op=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retire pulses once.
REQ-029 op=000000, funct=100111 -> alu_sel=101 in REX; RWB has reg_dst=1; 4 cycles total.
REQ-030 op=000101 in BRANCH: zero=1 -> alu_sel=111 and pc_en=1; zero=0 -> pc_en=0; return to FETCH after 3 cycles.
REQ-031 op=001101 -> IEX has alu_sel=011 and ext_zero=1; op=001010 -> alu_sel=110 and ext_zero=0.
REQ-032 op=111111, or op=000000 with funct=000001 -> DECODE goes to FETCH; no reg_write or mem_write.
REQ-033 Pull rst_n low mid-cycle during MEMWR -> state=0 and mem_write=0 before the next clk edge.
